// File: rtl/spi_pkg.sv
// Shared SPI definitions: one-hot FSM states, bus defaults
// and the sclk half-period divider computation.
package spi_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        LEAD  = 4'b0010,
        SHIFT = 4'b0100,
        DONE  = 4'b1000
    } spi_state_t;

    localparam int DEF_CLK_FREQ   = 50_000_000;
    localparam int DEF_SCLK_FREQ  = 5_000_000;
    localparam int DEF_DATA_WIDTH = 8;
    localparam bit DEF_CPOL       = 1'b0;
    localparam bit DEF_CPHA       = 1'b0;

    function automatic int half_div(
        input int clk_freq,
        input int sclk_freq
    );
        return clk_freq / (2 * sclk_freq);
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Free-running sclk half-period tick generator.
// Tick marks the last clk cycle of each half-period.
module spi_half_tick
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(HALF_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;

    // count 0..HALF_DIV-1, restarted by clr
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/spi_master_tx.sv
// SPI master transmitter: one word per start request,
// registered sclk / mosi / ss_n, no miso path.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int SCLK_FREQ  = DEF_SCLK_FREQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit CPOL       = DEF_CPOL,
    parameter bit CPHA       = DEF_CPHA,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  busy,
    output logic                  tx_finish,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  ss_n
);

    localparam int HALF_DIV = half_div(CLK_FREQ, SCLK_FREQ);
    localparam int NTOG     = 2 * DATA_WIDTH;
    localparam int TW       = $clog2(NTOG + 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(NTOG);
    localparam logic [TW-1:0] ADV_LAST = TW'(NTOG - 2);

    if (HALF_DIV < 1) begin : g_bad_div
        $error("spi_master_tx: HALF_DIV must be >= 1");
    end

    spi_state_t            state;
    spi_state_t            state_d;
    logic                  tick;
    logic                  toggle;
    logic                  advance;
    logic [TW-1:0]         tog_cnt;
    logic [TW-1:0]         tog_num;
    logic [DATA_WIDTH-1:0] sreg;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  ss_n_q;

    // next bit to leave the word, in the configured order
    function automatic logic head(
        input logic [DATA_WIDTH-1:0] w
    );
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    // drop the bit that head() just returned
    function automatic logic [DATA_WIDTH-1:0] drop(
        input logic [DATA_WIDTH-1:0] w
    );
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0}
                         : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    spi_half_tick #(
        .HALF_DIV (HALF_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // next state and sclk toggle request
    always_comb begin
        state_d = state;
        toggle  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d = SHIFT;
                    toggle  = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (tog_cnt == TOG_LAST) begin
                        state_d = DONE;
                    end else begin
                        toggle = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // toggle about to happen is number tog_cnt+1
    assign tog_num = tog_cnt + 1'b1;

    // data moves on the edges the receiver does not sample
    assign advance = CPHA ? (toggle && tog_num[0])
                          : (toggle && !tog_num[0] &&
                             (tog_num <= ADV_LAST));

    // sclk toggle counter, held clear while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            tog_cnt <= '0;
        end else if (state == IDLE) begin
            tog_cnt <= '0;
        end else if (toggle) begin
            tog_cnt <= tog_num;
        end
    end

    // shift register and mosi; CPHA=0 presents bit 0 at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg   <= '0;
            mosi_q <= 1'b0;
        end else if (state == IDLE && start) begin
            if (!CPHA) begin
                mosi_q <= head(data_i);
                sreg   <= drop(data_i);
            end else begin
                mosi_q <= 1'b0;
                sreg   <= data_i;
            end
        end else if (state_d == DONE || state_d == IDLE) begin
            mosi_q <= 1'b0;
        end else if (advance) begin
            mosi_q <= head(sreg);
            sreg   <= drop(sreg);
        end
    end

    // sclk and slave select pins
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= CPOL;
            ss_n_q <= 1'b1;
        end else begin
            ss_n_q <= !(state_d == LEAD || state_d == SHIFT);
            if (state_d == IDLE || state_d == DONE) begin
                sclk_q <= CPOL;
            end else if (toggle) begin
                sclk_q <= !sclk_q;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign tx_finish = (state == DONE);
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign ss_n      = ss_n_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Randomized bench for spi_master_tx over four configurations,
// checked cycle by cycle and word by word against a timing model.
module tb_spi_master_tx;

    localparam int NU = 4;
    localparam int DW = 8;

    localparam int HD    [NU] = '{5, 5, 1, 2};
    localparam bit CPOLV [NU] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam bit CPHAV [NU] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam bit MSBV  [NU] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic          clk = 1'b0;
    logic          rst;
    logic [NU-1:0] start;
    logic [NU-1:0] busy;
    logic [NU-1:0] fin;
    logic [NU-1:0] sclk;
    logic [NU-1:0] mosi;
    logic [NU-1:0] ss_n;
    logic [DW-1:0] din [NU];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_master_tx #(
        .DATA_WIDTH (8)
    ) u0 (
        .clk (clk), .rst (rst), .start (start[0]),
        .data_i (din[0]), .busy (busy[0]),
        .tx_finish (fin[0]), .sclk (sclk[0]),
        .mosi (mosi[0]), .ss_n (ss_n[0])
    );

    spi_master_tx #(
        .CPOL (1'b1),
        .CPHA (1'b1)
    ) u1 (
        .clk (clk), .rst (rst), .start (start[1]),
        .data_i (din[1]), .busy (busy[1]),
        .tx_finish (fin[1]), .sclk (sclk[1]),
        .mosi (mosi[1]), .ss_n (ss_n[1])
    );

    spi_master_tx #(
        .SCLK_FREQ (25_000_000),
        .MSB_FIRST (1'b1)
    ) u2 (
        .clk (clk), .rst (rst), .start (start[2]),
        .data_i (din[2]), .busy (busy[2]),
        .tx_finish (fin[2]), .sclk (sclk[2]),
        .mosi (mosi[2]), .ss_n (ss_n[2])
    );

    spi_master_tx #(
        .SCLK_FREQ (12_500_000),
        .CPHA      (1'b1)
    ) u3 (
        .clk (clk), .rst (rst), .start (start[3]),
        .data_i (din[3]), .busy (busy[3]),
        .tx_finish (fin[3]), .sclk (sclk[3]),
        .mosi (mosi[3]), .ss_n (ss_n[3])
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] expv
    );
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // {ss_n, sclk, mosi, busy, tx_finish} at cycle t after accept
    function automatic logic [4:0] model(
        input int            u,
        input logic [DW-1:0] d,
        input int            t
    );
        int   h;
        int   last;
        int   k;
        int   idx;
        logic b;
        h    = HD[u];
        last = h * (2 * DW + 1);
        if (t < 1 || t > last + 1)
            return {1'b1, CPOLV[u], 1'b0, 1'b0, 1'b0};
        if (t == last + 1)
            return {1'b1, CPOLV[u], 1'b0, 1'b1, 1'b1};
        k = (t <= h) ? 0 : (t - 1 - h) / h + 1;
        if (k > 2 * DW) k = 2 * DW;
        if (CPHAV[u]) idx = (k == 0) ? -1 : (k - 1) / 2;
        else idx = (k / 2 > DW - 1) ? DW - 1 : k / 2;
        if (idx < 0) b = 1'b0;
        else b = d[MSBV[u] ? DW - 1 - idx : idx];
        return {1'b0, CPOLV[u] ^ k[0], b, 1'b1, 1'b0};
    endfunction

    function automatic logic [4:0] obs(input int u);
        return {ss_n[u], sclk[u], mosi[u], busy[u], fin[u]};
    endfunction

    task automatic run_xfer(
        input int            u,
        input logic [DW-1:0] d,
        input int            stray1,
        input int            stray2,
        input bit            again,
        input int            rst_at
    );
        int            last;
        int            tend;
        int            words;
        int            nb;
        int            ntog;
        int            wexp;
        int            slast;
        logic          psclk;
        logic          pmosi;
        logic [4:0]    expv;
        logic [DW-1:0] w;
        last  = HD[u] * (2 * DW + 1);
        tend  = again ? 2 * (last + 2) + 1 : last + 3;
        slast = 2 * DW - (CPHAV[u] ? 0 : 1);
        if (rst_at > 0) begin
            tend = rst_at + 4;
            wexp = (rst_at >= 1 + slast * HD[u]) ? 1 : 0;
        end else begin
            wexp = again ? 2 : 1;
        end
        words = 0;
        nb    = 0;
        ntog  = 0;
        w     = '0;
        psclk = CPOLV[u];
        pmosi = 1'b0;
        @(posedge clk);
        #1;
        start[u] = 1'b1;
        din[u]   = d;
        check($sformatf("u%0d_t0", u), obs(u), model(u, d, 0));
        for (int t = 1; t <= tend; t++) begin
            @(posedge clk);
            #1;
            start[u] = (again && t <= last + 2) ||
                       t == stray1 || t == stray2;
            if (again) din[u] = d;
            else if (start[u]) din[u] = 8'hFF;
            else din[u] = DW'($urandom);
            rst = (t == rst_at);
            if (again && t > last + 2)
                expv = model(u, d, t - (last + 2));
            else if (rst_at > 0 && t > rst_at)
                expv = model(u, d, -1);
            else
                expv = model(u, d, t);
            check($sformatf("u%0d_t%0d", u, t), obs(u), expv);
            if (!ss_n[u] && sclk[u] != psclk) begin
                ntog++;
                if (ntog[0] ^ CPHAV[u]) begin
                    if (MSBV[u]) w = {w[DW-2:0], pmosi};
                    else w = {pmosi, w[DW-1:1]};
                    nb++;
                    if (nb == DW) begin
                        check($sformatf("u%0d_word", u), w, d);
                        words++;
                        nb = 0;
                    end
                end
            end
            psclk = sclk[u];
            pmosi = mosi[u];
        end
        start[u] = 1'b0;
        rst      = 1'b0;
        check($sformatf("u%0d_nwords", u), words, wexp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int last;
        int ra;
        bit ag;
        int s1;
        rst   = 1'b1;
        start = '0;
        for (int u = 0; u < NU; u++) din[u] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int u = 0; u < NU; u++)
            check($sformatf("u%0d_reset", u), obs(u),
                  model(u, '0, -1));

        run_xfer(0, 8'hA5, 0, 0, 1'b0, 0);
        run_xfer(1, 8'h3C, 0, 0, 1'b0, 0);
        run_xfer(0, 8'h01, 20, 86, 1'b0, 0);
        run_xfer(0, 8'h5A, 0, 0, 1'b1, 0);
        run_xfer(0, 8'hE7, 0, 0, 1'b0, 40);
        run_xfer(0, 8'hC3, 0, 0, 1'b0, 0);
        run_xfer(2, 8'h80, 0, 0, 1'b0, 0);
        run_xfer(3, 8'h96, 0, 0, 1'b0, 0);

        repeat (5) begin
            for (int u = 0; u < NU; u++) begin
                last = HD[u] * (2 * DW + 1);
                ra = ($urandom_range(0, 4) == 0) ?
                     int'($urandom_range(1, last)) : 0;
                ag = (ra == 0) && ($urandom_range(0, 3) == 0);
                s1 = (ra == 0) ? int'($urandom_range(0, last + 1)) : 0;
                run_xfer(u, DW'($urandom), s1, 0, ag, ra);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
